// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg -- shared RV32I decode definitions.
//
// Holds the major opcode constants, the ALU operation encoding, the branch
// comparison encoding, the bundle of raw immediates built by imm_gen, and
// the f3/bit30 to ALU-op mapping shared by OP and OP-IMM.
// -----------------------------------------------------------------------------
package rv_pkg;

   localparam int XLEN      = 32;
   localparam int ALU_OP_W  = 4;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // ALU operations for OP / OP-IMM
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001
   } alu_op_e;

   // Branch comparison codes, carried on the same alu_op output
   localparam logic [ALU_OP_W-1:0] BR_BEQ  = 4'b0000;
   localparam logic [ALU_OP_W-1:0] BR_BNE  = 4'b0001;
   localparam logic [ALU_OP_W-1:0] BR_BLT  = 4'b0010;
   localparam logic [ALU_OP_W-1:0] BR_BGE  = 4'b0011;
   localparam logic [ALU_OP_W-1:0] BR_BLTU = 4'b0100;
   localparam logic [ALU_OP_W-1:0] BR_BGEU = 4'b0101;

   // All sign-extended immediate formats of one instruction word
   typedef struct packed {
      logic [XLEN-1:0] i_imm;
      logic [XLEN-1:0] s_imm;
      logic [XLEN-1:0] b_imm;
      logic [XLEN-1:0] u_imm;
      logic [XLEN-1:0] j_imm;
   } imm_set_t;

   // f3/bit30 to ALU op. bit30 only selects SUB for register-register ops;
   // for OP-IMM it is part of the immediate, except on the shift-right slot.
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3,
                                           input logic       bit30,
                                           input logic       is_reg);
      alu_op_e op;
      unique case (f3)
         3'b000:  op = (is_reg && bit30) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen -- combinational immediate builder.
//
// Ports:
//   instr  in   32-bit instruction word
//   imms   out  I/S/B/U/J immediates, each sign-extended from instr[31]
// -----------------------------------------------------------------------------
module imm_gen
   import rv_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   output imm_set_t        imms
);

   logic sign;
   assign sign = instr[31];

   assign imms.i_imm = {{20{sign}}, instr[31:20]};
   assign imms.s_imm = {{20{sign}}, instr[31:25], instr[11:7]};
   assign imms.b_imm = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imms.u_imm = {instr[31:12], 12'b0};
   assign imms.j_imm = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

endmodule

// File: rtl/decoder.sv
// -----------------------------------------------------------------------------
// decoder -- RV32I instruction decoder with registered outputs.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset, clears all outputs
//   instr   in   32-bit instruction word, decoded every cycle
//   imm     out  sign-extended I/S/U/J immediate (0 for branch, R-type, unknown)
//   immB    out  sign-extended branch offset (0 unless BRANCH)
//   alu_op  out  ALU operation (OP/OP-IMM) or comparison code (BRANCH)
//   rd      out  instr[11:7]
//   rs1     out  instr[19:15]
//   rs2     out  instr[24:20]
// -----------------------------------------------------------------------------
module decoder
   import rv_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [XLEN-1:0]     instr,
   output logic [XLEN-1:0]     imm,
   output logic [XLEN-1:0]     immB,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [4:0]          rd,
   output logic [4:0]          rs1,
   output logic [4:0]          rs2
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic       bit30;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign bit30  = instr[30];

   imm_set_t imms;

   imm_gen u_imm_gen (
      .instr (instr),
      .imms  (imms)
   );

   logic [XLEN-1:0]     imm_d;
   logic [XLEN-1:0]     immb_d;
   logic [ALU_OP_W-1:0] alu_op_d;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      imm_d    = '0;
      immb_d   = '0;
      alu_op_d = ALU_ADD;

      unique case (opcode)
         OPC_OP_IMM: begin
            // Full 12-bit field is kept even for shifts (SRAI -> 0x403).
            imm_d    = imms.i_imm;
            alu_op_d = alu_from_f3(f3, bit30, 1'b0);
         end
         OPC_OP: begin
            alu_op_d = alu_from_f3(f3, bit30, 1'b1);
         end
         OPC_BRANCH: begin
            immb_d = imms.b_imm;
            unique case (f3)
               3'b000:  alu_op_d = BR_BEQ;
               3'b001:  alu_op_d = BR_BNE;
               3'b100:  alu_op_d = BR_BLT;
               3'b101:  alu_op_d = BR_BGE;
               3'b110:  alu_op_d = BR_BLTU;
               3'b111:  alu_op_d = BR_BGEU;
               default: alu_op_d = BR_BEQ;  // reserved f3 010/011
            endcase
         end
         OPC_LOAD,
         OPC_JALR:   imm_d = imms.i_imm;
         OPC_STORE:  imm_d = imms.s_imm;
         OPC_LUI,
         OPC_AUIPC:  imm_d = imms.u_imm;
         OPC_JAL:    imm_d = imms.j_imm;
         default:    ;  // unknown opcode keeps the zero defaults
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: non-blocking assignments for all registered state, so every
         // flop samples the pre-edge value regardless of statement order.
         imm    <= '0;
         immB   <= '0;
         alu_op <= '0;
         rd     <= '0;
         rs1    <= '0;
         rs2    <= '0;
      end else begin
         imm    <= imm_d;
         immB   <= immb_d;
         alu_op <= alu_op_d;
         rd     <= instr[11:7];
         rs1    <= instr[19:15];
         rs2    <= instr[24:20];
      end
   end

endmodule

// File: tb/tb_decoder.sv
// -----------------------------------------------------------------------------
// tb_decoder -- self-checking bench for decoder.
// Expected decode results are pushed to a scoreboard queue as each instruction
// is driven and popped and compared one cycle later when the outputs settle.
// -----------------------------------------------------------------------------
module tb_decoder;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic [31:0] imm;
   logic [31:0] immB;
   logic [3:0]  alu_op;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;

   decoder dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .instr  (instr),
      .imm    (imm),
      .immB   (immB),
      .alu_op (alu_op),
      .rd     (rd),
      .rs1    (rs1),
      .rs2    (rs2)
   );

   typedef struct packed {
      logic [31:0] imm;
      logic [31:0] immb;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } dec_t;

   dec_t obs;
   assign obs = {imm, immB, alu_op, rd, rs1, rs2};

   dec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the bench must always end on its own.
   initial begin
      #200000;
      $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
      $fatal(1, "timeout");
   end

   // Expected record: register fields are raw slices of the word.
   function automatic dec_t mk(input logic [31:0] w, input logic [31:0] e_imm,
                               input logic [31:0] e_immb, input logic [3:0] e_op);
      dec_t e;
      e.imm  = e_imm;
      e.immb = e_immb;
      e.op   = e_op;
      e.rd   = w[11:7];
      e.rs1  = w[19:15];
      e.rs2  = w[24:20];
      return e;
   endfunction

   // Present one word, record its expected decode, let one edge pass.
   task automatic drive(input logic [31:0] w, input dec_t e);
      @(negedge clk);
      instr = w;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      dec_t e, got;
      rst_n = 1'b1;
      instr = 32'h00310293;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL reset_async: got imm=%h immB=%h op=%h rd=%0d rs1=%0d rs2=%0d, expected all 0",
                  imm, immB, alu_op, rd, rs1, rs2);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sb.push_back(mk(32'h00310293, 32'h00000003, 32'h0, 4'b0000));
      @(posedge clk);
      #1;
      got = obs;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL reset_release: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (got !== e || rd !== 5'd5 || rs1 !== 5'd2) begin
            errors++;
            $display("FAIL reset_release: got %h, expected %h", got, e);
         end
      end
   endtask

   task automatic test_op_imm();
      logic [2:0]  f3s [9] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111, 3'b001, 3'b101, 3'b101};
      logic [3:0]  ops [9] = '{4'b0000, 4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b0010, 4'b0110, 4'b0111};
      logic [11:0] fld [9] = '{12'h003, 12'h003, 12'h003, 12'h003, 12'h003, 12'h003, 12'h003, 12'h003, 12'h403};
      dec_t e, got;
      logic [31:0] w;
      for (int i = 0; i < 9; i++) begin
         w = {fld[i], 5'd2, f3s[i], 5'd5, 7'b0010011};
         drive(w, mk(w, {20'h0, fld[i]}, 32'h0, ops[i]));
         got = obs;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL op_imm[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL op_imm[%0d]: got imm=%h immB=%h op=%b, expected imm=%h immB=%h op=%b",
                        i, got.imm, got.immb, got.op, e.imm, e.immb, e.op);
            end
         end
      end
   endtask

   task automatic test_branch();
      logic [2:0] f3s [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
      logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0000, 4'b0000};
      dec_t e, got;
      logic [31:0] w;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) begin
            w = {7'b0, 5'd0, 5'd2, f3s[i], 5'b00010, 7'b1100011};
            drive(w, mk(w, 32'h0, 32'h00000002, ops[i]));
         end else begin
            // Only the sign bit set: offset -4096.
            w = {1'b1, 6'b0, 5'd0, 5'd2, 3'b000, 5'b00000, 7'b1100011};
            drive(w, mk(w, 32'h0, 32'hFFFFF000, 4'b0000));
         end
         got = obs;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL branch[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL branch[%0d]: got imm=%h immB=%h op=%b, expected imm=%h immB=%h op=%b",
                        i, got.imm, got.immb, got.op, e.imm, e.immb, e.op);
            end
         end
      end
   endtask

   task automatic test_rtype();
      logic [31:0] ws  [4] = '{32'h402081B3, 32'h002081B3, 32'h4020D1B3, 32'h4020E1B3};
      logic [3:0]  ops [4] = '{4'b0001, 4'b0000, 4'b0111, 4'b1000};
      dec_t e, got;
      for (int i = 0; i < 4; i++) begin
         drive(ws[i], mk(ws[i], 32'h0, 32'h0, ops[i]));
         got = obs;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL rtype[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (got !== e || rd !== 5'd3 || rs1 !== 5'd1 || rs2 !== 5'd2) begin
               errors++;
               $display("FAIL rtype[%0d]: got %h, expected %h", i, got, e);
            end
         end
      end
   endtask

   task automatic test_other_formats();
      logic [31:0] ws   [7];
      logic [31:0] imms [7];
      dec_t e, got;
      ws[0] = 32'h123452B7;                                          imms[0] = 32'h12345000; // LUI
      ws[1] = {7'h7F, 5'd5, 5'd2, 3'b010, 5'b11100, 7'b0100011};     imms[1] = 32'hFFFFFFFC; // SW -4
      ws[2] = 32'h0000007F;                                          imms[2] = 32'h0;        // unknown
      ws[3] = {12'hFFF, 5'd2, 3'b010, 5'd5, 7'b0000011};             imms[3] = 32'hFFFFFFFF; // LW -1
      ws[4] = {20'hFFFFF, 5'd1, 7'b0010111};                         imms[4] = 32'hFFFFF000; // AUIPC
      ws[5] = {1'b0, 10'd4, 1'b0, 8'd0, 5'd1, 7'b1101111};           imms[5] = 32'h00000008; // JAL +8
      ws[6] = {12'h010, 5'd1, 3'b000, 5'd0, 7'b1100111};             imms[6] = 32'h00000010; // JALR
      for (int i = 0; i < 7; i++) begin
         drive(ws[i], mk(ws[i], imms[i], 32'h0, 4'b0000));
         got = obs;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL other[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL other[%0d]: got imm=%h immB=%h op=%b rd=%0d, expected imm=%h immB=%h op=%b rd=%0d",
                        i, got.imm, got.immb, got.op, got.rd, e.imm, e.immb, e.op, e.rd);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      dec_t e, got;
      logic [31:0] w;
      w = 32'h402081B3;
      drive(w, mk(w, 32'h0, 32'h0, 4'b0001));
      void'(sb.pop_front());
      // Assert reset between edges: outputs must clear without a clock.
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("FAIL mid_reset_clear: got %h, expected 0", obs);
      end
      @(negedge clk);
      rst_n = 1'b1;
      w = {12'h403, 5'd7, 3'b101, 5'd9, 7'b0010011};
      instr = w;
      sb.push_back(mk(w, 32'h00000403, 32'h0, 4'b0111));
      @(posedge clk);
      #1;
      got = obs;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL mid_reset_release: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (got !== e) begin
            errors++;
            $display("FAIL mid_reset_release: got %h, expected %h", got, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_op_imm();
      test_branch();
      test_rtype();
      test_other_formats();
      test_mid_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Instruction decoder for the RV32I multicycle core; sits between the instruction register and the register file / ALU / branch unit.
- Takes a 32-bit instruction and produces the register indices, sign-extended immediates and a 4-bit ALU/branch operation code.
- Outputs are registered, so decode results are stable for the following execute step.

Parameters:
- none (XLEN fixed at 32, ALU op width fixed at 4)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction word to decode
- imm  out  32  sign-extended I/S/U/J immediate; 0 for branch and R-type
- immB  out  32  sign-extended B-type branch offset; 0 for non-branch
- alu_op  out  4  ALU operation (OP/OP-IMM) or comparison code (BRANCH)
- rd  out  5  destination register, instr[11:7]
- rs1  out  5  source register 1, instr[19:15]
- rs2  out  5  source register 2, instr[24:20]

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: while rst_n=0, all outputs are 0 immediately, independent of clk.
- Latency: all outputs register the decode of instr on each rising clk edge (1 cycle). There is no enable and no handshake; decode runs every cycle.
- rd, rs1 and rs2 are always the raw instruction fields, whatever the opcode.
- Decode is keyed on opcode = instr[6:0], f3 = instr[14:12] and bit30 = instr[30].
- OP-IMM (0010011):
  - imm = sext(instr[31:20]); immB = 0.
  - The full 12 bits are kept for shifts, so SRAI with shamt 3 gives imm = 0x403.
  - alu_op by f3: 000 ADDI=0000, 001 SLLI=0010, 010 SLTI=0011, 011 SLTIU=0100, 100 XORI=0101, 101 SRLI=0110 (bit30=0) or SRAI=0111 (bit30=1), 110 ORI=1000, 111 ANDI=1001.
- OP (0110011):
  - imm = 0; immB = 0.
  - alu_op uses the OP-IMM mapping, plus: f3=000 with bit30=1 gives SUB=0001, and f3=101 with bit30=1 gives SRA=0111.
- BRANCH (1100011):
  - imm = 0; immB = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - alu_op by f3: 000 BEQ=0000, 001 BNE=0001, 100 BLT=0010, 101 BGE=0011, 110 BLTU=0100, 111 BGEU=0101.
  - f3 = 010 or 011: alu_op = 0000.
- LOAD (0000011), JALR (1100111): imm = sext(instr[31:20]); alu_op = 0000.
- STORE (0100011): imm = sext({instr[31:25], instr[11:7]}); alu_op = 0000.
- LUI (0110111), AUIPC (0010111): imm = {instr[31:12], 12'b0}; alu_op = 0000.
- JAL (1101111): imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); alu_op = 0000.
- immB is 0 for every opcode except BRANCH.
- Any other opcode: imm = 0, immB = 0, alu_op = 0000; rd/rs1/rs2 still pass through.
- Sign extension always uses instr[31], so negative offsets yield upper bits all 1.
- If reset is asserted mid-stream, outputs clear at once. The first rising edge after deassertion decodes the instr presented at that edge.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants: OPC_OP_IMM, OPC_OP, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR
  - ALU op enum/constants: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
  - branch-op constants: BEQ..BGEU
- One combinational sub-module, imm_gen, produces the I/S/B/U/J immediates from instr. decoder selects among them and registers the results.

Test Plan:
- Reset: drive rst_n=0 with instr=0x00310293 -> all outputs 0 without a clock edge. Release reset, one edge -> imm=0x00000003, alu_op=0000, rd=5, rs1=2.
- OP-IMM sweep: instr = {12'h003, rs1=2, f3, rd=5, 0010011}, f3 over 000,010,011,100,110,111,001,101 -> imm=0x00000003, immB=0, alu_op = 0000,0011,0100,0101,1000,1001,0010,0110 respectively. SRAI with imm field 0x403 -> imm=0x00000403, alu_op=0111.
- Branch sweep: instr = {7'b0, rs2=0, rs1=2, f3, 5'b00010, 1100011}, f3 over 000,001,100,101,110,111 -> imm=0, immB=0x00000002, alu_op = 0000..0101.
- Negative branch offset: BEQ with instr[31]=1 and all other immediate bits 0 -> immB=0xFFFFF000.
- R-type: SUB x3,x1,x2 (0x402081B3) -> alu_op=0001, imm=0, rd=3, rs1=1, rs2=2. ADD (0x002081B3) -> alu_op=0000.
- Other formats: LUI 0x123452B7 -> imm=0x12345000. SW with offset -4 -> imm=0xFFFFFFFC. Unknown opcode 0x0000007F -> imm=0, immB=0, alu_op=0.
